inst_fetch_unit: RTL and testbench

Instruction-side bus front end between the pipelined RV32I core and instruction memory. It turns the core's fetch PC into single-outstanding memory requests with a req/gnt/rvalid handshake. It holds a 2-entry tagged word buffer with optional next-word prefetch. It returns the instruction, a stall signal and an access-fault flag, which drive the core's inst, inst_stall and inst_access_fault inputs.

---
 rtl/ifu_pkg.sv | 25 ++
 rtl/ifu_line_buffer.sv | 77 +++++++
 rtl/inst_fetch_unit.sv | 137 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit and its word buffer.
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RVALID,
    ST_DRAIN
  } ifu_state_e;

  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam int          NUM_ENTRIES = 2;

  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] data;
    logic        err;
  } ifu_entry_t;

  function automatic logic tag_match(input ifu_entry_t e, input logic [29:0] t);
    return e.valid && (e.tag == t);
  endfunction

endpackage

// File: rtl/ifu_line_buffer.sv
// Two-entry tagged word buffer: looks up the fetch word and its successor, and
// fills either the entry already holding the tag or the round-robin victim.
module ifu_line_buffer
  import ifu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] lookup_tag,
  input  logic [29:0] next_tag,
  output logic        hit,
  output logic [31:0] hit_data,
  output logic        hit_err,
  output logic        next_present,
  input  logic        fill_en,
  input  logic [29:0] fill_tag,
  input  logic [31:0] fill_data,
  input  logic        fill_err
);

  ifu_entry_t                 entry_reg [NUM_ENTRIES];
  logic                       victim_reg;
  logic [NUM_ENTRIES-1:0]     lookup_match;
  logic [NUM_ENTRIES-1:0]     next_match;
  logic [NUM_ENTRIES-1:0]     fill_match;
  logic [NUM_ENTRIES-1:0]     fill_sel;
  logic                       fill_idx;
  ifu_entry_t                 fill_entry;

  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_cmp
      assign lookup_match[gi] = tag_match(entry_reg[gi], lookup_tag);
      assign next_match[gi]   = tag_match(entry_reg[gi], next_tag);
      assign fill_match[gi]   = tag_match(entry_reg[gi], fill_tag);
      assign fill_sel[gi]     = fill_en && (fill_idx == 1'(gi));
    end
  endgenerate

  assign hit          = |lookup_match;
  assign next_present = |next_match;

  // Fills never duplicate a tag, so at most one entry can match any lookup.
  always_comb begin
    hit_data = '0;
    hit_err  = 1'b0;
    fill_idx = victim_reg;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (lookup_match[i]) begin
        hit_data = entry_reg[i].data;
        hit_err  = entry_reg[i].err;
      end
      if (fill_match[i]) begin
        fill_idx = 1'(i);
      end
    end
  end

  assign fill_entry = '{valid: 1'b1, tag: fill_tag, data: fill_data, err: fill_err};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      victim_reg <= 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entry_reg[i] <= '0;
      end
    end else begin
      if (fill_en) begin
        victim_reg <= ~victim_reg;
      end
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (fill_sel[i]) begin
          entry_reg[i] <= fill_entry;
        end
      end
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-side bus front end: single-outstanding req/gnt/rvalid fetches into a
// two-entry word buffer, with optional next-word prefetch and a response timeout.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int          PREFETCH = 1,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] NOP      = NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  output logic [31:0] inst_o,
  output logic        inst_stall_o,
  output logic        inst_access_fault_o,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err
);

  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  ifu_state_e       state_reg;
  logic [29:0]      addr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             req_reg;

  logic [29:0] pc_tag;
  logic [29:0] next_tag;
  logic        buf_hit;
  logic [31:0] buf_data;
  logic        buf_err;
  logic        next_present;
  logic        bypass_hit;
  logic        fill_en;
  logic [31:0] fill_data;
  logic        fill_err;
  logic        unused_pc_bits;

  assign pc_tag         = pc_i[31:2];
  assign next_tag       = pc_i[31:2] + 30'd1;
  assign unused_pc_bits = &{1'b0, pc_i[1:0]};

  ifu_line_buffer u_line_buffer (
    .clk          (clk),
    .reset        (reset),
    .lookup_tag   (pc_tag),
    .next_tag     (next_tag),
    .hit          (buf_hit),
    .hit_data     (buf_data),
    .hit_err      (buf_err),
    .next_present (next_present),
    .fill_en      (fill_en),
    .fill_tag     (addr_reg),
    .fill_data    (fill_data),
    .fill_err     (fill_err)
  );

  // A timeout fills a faulted NOP entry so the core traps instead of stalling forever.
  assign fill_en   = (state_reg == ST_WAIT_RVALID) && (imem_rvalid || (cnt_reg == CNT_LAST));
  assign fill_data = imem_rvalid ? imem_rdata : NOP;
  assign fill_err  = imem_rvalid ? imem_err : 1'b1;

  assign bypass_hit = (state_reg == ST_WAIT_RVALID) && imem_rvalid && (addr_reg == pc_tag);

  always_comb begin
    inst_o              = NOP;
    inst_stall_o        = 1'b1;
    inst_access_fault_o = 1'b0;
    if (buf_hit) begin
      inst_stall_o = 1'b0;
      if (buf_err) inst_access_fault_o = 1'b1;
      else         inst_o = buf_data;
    end else if (bypass_hit) begin
      inst_stall_o = 1'b0;
      if (imem_err) inst_access_fault_o = 1'b1;
      else          inst_o = imem_rdata;
    end
  end

  assign imem_req  = req_reg;
  assign imem_addr = {addr_reg, 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      req_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!buf_hit) begin
            addr_reg  <= pc_tag;
            req_reg   <= 1'b1;
            state_reg <= ST_REQ;
          end else if ((PREFETCH != 0) && !next_present) begin
            addr_reg  <= next_tag;
            req_reg   <= 1'b1;
            state_reg <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (imem_gnt) begin
            req_reg   <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= ST_WAIT_RVALID;
          end
        end
        ST_WAIT_RVALID: begin
          if (imem_rvalid) begin
            state_reg <= ST_IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            state_reg <= ST_DRAIN;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DRAIN: begin
          // A late response belongs to the abandoned access and is dropped.
          if (imem_rvalid || (cnt_reg == CNT_LAST)) begin
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a small scripted instruction memory.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] inst_o;
  logic        inst_stall_o;
  logic        inst_access_fault_o;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_err = 1'b0;

  int checks = 0;
  int errors = 0;

  // Memory script knobs, changed by the stimulus process.
  int          wait_left = 0;
  int          resp_lat  = 1;
  int          resp_cnt  = 0;
  logic [31:0] resp_addr = '0;
  logic [31:0] err_addr  = 32'hFFFF_FFFC;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .PREFETCH (1),
    .TIMEOUT  (4),
    .NOP      (32'h0000_0013)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .pc_i                (pc_i),
    .inst_o              (inst_o),
    .inst_stall_o        (inst_stall_o),
    .inst_access_fault_o (inst_access_fault_o),
    .imem_req            (imem_req),
    .imem_addr           (imem_addr),
    .imem_gnt            (imem_gnt),
    .imem_rvalid         (imem_rvalid),
    .imem_rdata          (imem_rdata),
    .imem_err            (imem_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a << 16) | 32'h0000_0113;
  endfunction

  // Memory side: drives gnt/rvalid on the falling edge so the DUT samples them at the next rise.
  initial begin
    forever begin
      @(negedge clk);
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_err    = 1'b0;
      imem_rdata  = '0;
      if (resp_cnt > 0) begin
        resp_cnt = resp_cnt - 1;
        if (resp_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(resp_addr);
          imem_err    = (resp_addr == err_addr);
        end
      end
      if (imem_req) begin
        if (wait_left > 0) begin
          wait_left = wait_left - 1;
        end else begin
          imem_gnt  = 1'b1;
          resp_addr = imem_addr;
          resp_cnt  = resp_lat;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %-14s got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %-14s %h", tag, got);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) cyc();
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_i = v;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time %0t expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    cyc(); cyc();
    check_eq("rst_stall", 32'(inst_stall_o), 32'd1);
    check_eq("rst_inst", inst_o, 32'h13);
    check_eq("rst_fault", 32'(inst_access_fault_o), 32'd0);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);

    // First miss at pc 0: req next cycle, bypass data the cycle after, then prefetch 4
    reset = 1'b1;
    cyc();
    check_eq("c1_req", 32'(imem_req), 32'd1);
    check_eq("c1_addr", imem_addr, 32'h0);
    check_eq("c1_stall", 32'(inst_stall_o), 32'd1);
    cyc();
    check_eq("c2_bypass", inst_o, 32'h0050_0093);
    check_eq("c2_stall", 32'(inst_stall_o), 32'd0);
    cyc();
    check_eq("c3_hit", inst_o, 32'h0050_0093);
    check_eq("c3_req", 32'(imem_req), 32'd0);
    cyc();
    check_eq("pf4_req", 32'(imem_req), 32'd1);
    check_eq("pf4_addr", imem_addr, 32'h4);
    cyc(); cyc();

    // Sequential fetch: 4 and 8 hit thanks to prefetch
    set_pc(32'h4);
    check_eq("pc4_inst", inst_o, 32'h0004_0113);
    check_eq("pc4_stall", 32'(inst_stall_o), 32'd0);
    cyc();
    check_eq("pf8_addr", imem_addr, 32'h8);
    check_eq("pc4_stall_b", 32'(inst_stall_o), 32'd0);
    cyc();
    check_eq("pc4_stall_c", 32'(inst_stall_o), 32'd0);
    cyc();
    set_pc(32'h8);
    check_eq("pc8_inst", inst_o, 32'h0008_0113);
    check_eq("pc8_stall", 32'(inst_stall_o), 32'd0);
    settle(8);

    // Grant held off for 5 cycles: request must stay stable
    wait_left = 5;
    set_pc(32'h40);
    check_eq("g_miss_stall", 32'(inst_stall_o), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      check_eq("g_hold_req", 32'(imem_req), 32'd1);
      check_eq("g_hold_addr", imem_addr, 32'h40);
      check_eq("g_hold_stall", 32'(inst_stall_o), 32'd1);
    end
    cyc();
    cyc();
    check_eq("g_data", inst_o, 32'h0040_0113);
    check_eq("g_stall", 32'(inst_stall_o), 32'd0);
    settle(8);

    // Bus error on 0x100: faulted NOP, repeated on revisit
    err_addr = 32'h100;
    set_pc(32'h100);
    check_eq("e_stall", 32'(inst_stall_o), 32'd1);
    cyc();
    cyc();
    check_eq("e_fault", 32'(inst_access_fault_o), 32'd1);
    check_eq("e_inst", inst_o, 32'h13);
    check_eq("e_stall0", 32'(inst_stall_o), 32'd0);
    cyc();
    check_eq("e_hit_fault", 32'(inst_access_fault_o), 32'd1);
    check_eq("e_hit_stall", 32'(inst_stall_o), 32'd0);
    cyc(); cyc(); cyc();
    set_pc(32'h104);
    check_eq("e_next_inst", inst_o, 32'h0104_0113);
    check_eq("e_next_fault", 32'(inst_access_fault_o), 32'd0);
    cyc();
    set_pc(32'h100);
    check_eq("e_rev_fault", 32'(inst_access_fault_o), 32'd1);
    check_eq("e_rev_inst", inst_o, 32'h13);
    check_eq("e_rev_stall", 32'(inst_stall_o), 32'd0);
    settle(16);

    // Timeout (4 cycles) then a late response arriving in DRAIN
    resp_lat = 6;
    set_pc(32'h200);
    cyc();
    check_eq("t_req", 32'(imem_req), 32'd1);
    check_eq("t_addr", imem_addr, 32'h200);
    for (int k = 0; k < 4; k++) begin
      cyc();
      check_eq("t_wait_stall", 32'(inst_stall_o), 32'd1);
    end
    cyc();
    check_eq("t_fault", 32'(inst_access_fault_o), 32'd1);
    check_eq("t_inst", inst_o, 32'h13);
    check_eq("t_stall", 32'(inst_stall_o), 32'd0);
    check_eq("t_drain_req", 32'(imem_req), 32'd0);
    cyc();
    resp_lat = 1;
    check_eq("t_late_fault", 32'(inst_access_fault_o), 32'd1);
    check_eq("t_late_inst", inst_o, 32'h13);
    check_eq("t_late_req", 32'(imem_req), 32'd0);
    cyc();
    check_eq("t_idle_req", 32'(imem_req), 32'd0);
    cyc();
    check_eq("t_pf_req", 32'(imem_req), 32'd1);
    check_eq("t_pf_addr", imem_addr, 32'h204);
    settle(8);

    // Redirect from 0x20 to 0x80 while 0x20 is in flight
    resp_lat = 3;
    set_pc(32'h20);
    check_eq("r_stall0", 32'(inst_stall_o), 32'd1);
    cyc();
    check_eq("r_addr20", imem_addr, 32'h20);
    cyc();
    set_pc(32'h80);
    check_eq("r_stall1", 32'(inst_stall_o), 32'd1);
    cyc();
    check_eq("r_stall2", 32'(inst_stall_o), 32'd1);
    cyc();
    check_eq("r_stall3", 32'(inst_stall_o), 32'd1);
    cyc();
    check_eq("r_stall4", 32'(inst_stall_o), 32'd1);
    check_eq("r_req_idle", 32'(imem_req), 32'd0);
    cyc();
    check_eq("r_req80", 32'(imem_req), 32'd1);
    check_eq("r_addr80", imem_addr, 32'h80);
    cyc();
    check_eq("r_stall5", 32'(inst_stall_o), 32'd1);
    cyc();
    check_eq("r_stall6", 32'(inst_stall_o), 32'd1);
    cyc();
    check_eq("r_data80", inst_o, 32'h0080_0113);
    check_eq("r_stall80", 32'(inst_stall_o), 32'd0);
    cyc();
    set_pc(32'h20);
    check_eq("r_hit20", inst_o, 32'h0020_0113);
    check_eq("r_stall20", 32'(inst_stall_o), 32'd0);
    resp_lat = 1;
    settle(8);

    // Reset asserted mid-request clears request and buffer
    set_pc(32'h300);
    cyc();
    check_eq("m_req", 32'(imem_req), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("m_rst_req", 32'(imem_req), 32'd0);
    check_eq("m_rst_addr", imem_addr, 32'h0);
    check_eq("m_rst_stall", 32'(inst_stall_o), 32'd1);
    cyc(); cyc(); cyc();
    reset = 1'b1;
    set_pc(32'h20);
    check_eq("m_cleared", 32'(inst_stall_o), 32'd1);
    settle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
